// File: rtl/mem_arbiter_pkg.sv
// Encodings shared by the memory arbiter and any bus monitors watching it.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  // Round-robin pick: a lone requester wins, on conflict the one not served last wins.
  function automatic logic rr_pick(input logic i_ifu, input logic i_lsu, input logic i_last);
    logic w_pick;
    if (i_ifu && i_lsu) begin
      w_pick = (i_last == GNT_LSU) ? GNT_IFU : GNT_LSU;
    end else if (i_lsu) begin
      w_pick = GNT_LSU;
    end else begin
      w_pick = GNT_IFU;
    end
    return w_pick;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction
// at a time, with round-robin arbitration and a watchdog on a stalled memory.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]        r_state;
  logic              r_grant;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [MASK_W-1:0] r_wmask;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;

  logic             w_anyReq;
  logic             w_winner;
  logic             w_accept;
  logic             w_rspPhase;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_timeout;

  assign w_anyReq      = ifu_req_valid | lsu_req_valid;
  assign w_winner      = rr_pick(ifu_req_valid, lsu_req_valid, r_grant);
  assign w_accept      = (r_state == ST_IDLE) && w_anyReq;
  assign ifu_req_ready = w_accept && (w_winner == GNT_IFU);
  assign lsu_req_ready = w_accept && (w_winner == GNT_LSU);

  // Saturating watchdog; a TIMEOUT of zero never fires.
  assign w_cntNext = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_timeout = (TIMEOUT != 0) && (w_cntNext == CNT_W'(TIMEOUT));

  assign mem_req_valid = (r_state == ST_REQ);
  assign mem_addr      = r_addr;
  assign mem_wen       = r_wen;
  assign mem_wdata     = r_wdata;
  assign mem_wmask     = r_wmask;

  assign w_rspPhase    = (r_state == ST_RSP);
  assign ifu_rsp_valid = w_rspPhase && (r_grant == GNT_IFU);
  assign lsu_rsp_valid = w_rspPhase && (r_grant == GNT_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? r_rdata : '0;
  assign lsu_rdata     = lsu_rsp_valid ? r_rdata : '0;
  assign ifu_err       = ifu_rsp_valid & r_err;
  assign lsu_err       = lsu_rsp_valid & r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= GNT_LSU;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_grant <= w_winner;
            r_state <= ST_REQ;
            if (w_winner == GNT_LSU) begin
              r_addr  <= lsu_addr;
              r_wen   <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_wen   <= 1'b0;
              r_wdata <= '0;
              r_wmask <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= w_cntNext;
          // A response arriving on the timeout cycle still counts as a success.
          if (mem_rsp_valid) begin
            r_rdata <= r_wen ? '0 : mem_rdata;
            r_err   <= 1'b0;
            r_state <= ST_RSP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RSP;
          end
        end
        ST_RSP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
